// File: rtl/rand_point_scheduler.sv
// Places up to NUM_POINTS lit 16x16 cells per frame by rejection-sampling rand_num, then draws them as RGB222.
// Optional per-point random colour capture is enabled by defining RAND_POINT_COLOR_EN.
module rand_point_scheduler #(
  parameter int NUM_POINTS = 8,
  parameter int CELL_SHIFT = 4,
  parameter int COLS       = 40,
  parameter int ROWS       = 30,
  parameter int MAX_TRIES  = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] rand_num,
  input  logic        frame_start,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        video_active,
  output logic [5:0]  rgb,
  output logic        busy,
  output logic [4:0]  num_valid
);

`ifdef RAND_POINT_COLOR_EN
  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    CAPTURE       = 2'd1,
    SHOW          = 2'd2,
    CAPTURE_COLOR = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SHOW    = 2'd2
  } state_e;
`endif

  state_e state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [7:0] tries_q, tries_d, tries_inc;

  logic [NUM_POINTS-1:0] valid_q;
  logic [5:0] x_q [NUM_POINTS];
  logic [5:0] y_q [NUM_POINTS];
`ifdef RAND_POINT_COLOR_EN
  logic [5:0] col_q [NUM_POINTS];
  logic [5:0] col_store;
`endif

  logic [5:0] sample_x, sample_y;
  logic       accept;
  logic       clear, pos_we, col_we;
  logic [5:0] cell_x, cell_y;
  logic       hit;
  logic [5:0] hit_col;
  logic [5:0] rgb_q;

  assign sample_x  = rand_num[11:6];
  assign sample_y  = rand_num[5:0];
  assign accept    = ({1'b0, sample_x} < 7'(COLS)) && ({1'b0, sample_y} < 7'(ROWS));
  assign tries_inc = (tries_q == 8'hFF) ? tries_q : tries_q + 8'd1;
  assign cell_x    = 6'(pix_x >> CELL_SHIFT);
  assign cell_y    = 6'(pix_y >> CELL_SHIFT);
`ifdef RAND_POINT_COLOR_EN
  assign col_store = (rand_num[5:0] == 6'h00) ? 6'h3F : rand_num[5:0];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tries_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tries_q <= tries_d;
    end
  end

  // frame_start restarts from any state and overrides any same-cycle slot write.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tries_d = tries_q;
    clear   = 1'b0;
    pos_we  = 1'b0;
    col_we  = 1'b0;
    if (frame_start) begin
      clear   = 1'b1;
      idx_d   = '0;
      tries_d = '0;
      state_d = CAPTURE;
    end else begin
      case (state_q)
        CAPTURE: begin
          tries_d = tries_inc;
          if (accept) begin
            pos_we = 1'b1;
`ifdef RAND_POINT_COLOR_EN
            state_d = CAPTURE_COLOR;
`else
            idx_d = idx_q + 5'd1;
`endif
          end
`ifdef RAND_POINT_COLOR_EN
          if (!accept && tries_d == 8'(MAX_TRIES)) state_d = SHOW;
`else
          if (idx_d == 5'(NUM_POINTS) || tries_d == 8'(MAX_TRIES)) state_d = SHOW;
`endif
        end
`ifdef RAND_POINT_COLOR_EN
        CAPTURE_COLOR: begin
          col_we = 1'b1;
          idx_d  = idx_q + 5'd1;
          if (idx_d == 5'(NUM_POINTS) || tries_q == 8'(MAX_TRIES)) state_d = SHOW;
          else state_d = CAPTURE;
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    busy = (state_q == CAPTURE);
`ifdef RAND_POINT_COLOR_EN
    if (state_q == CAPTURE_COLOR) busy = 1'b1;
`endif
    num_valid = idx_q;
    rgb       = rgb_q;
  end

  // With colour capture, a slot becomes visible only once its colour is stored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int k = 0; k < NUM_POINTS; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
`ifdef RAND_POINT_COLOR_EN
        col_q[k] <= '0;
`endif
      end
    end else if (clear) begin
      valid_q <= '0;
    end else begin
      for (int k = 0; k < NUM_POINTS; k++) begin
        if (pos_we && idx_q == 5'(k)) begin
          x_q[k] <= sample_x;
          y_q[k] <= sample_y;
`ifndef RAND_POINT_COLOR_EN
          valid_q[k] <= 1'b1;
`endif
        end
`ifdef RAND_POINT_COLOR_EN
        if (col_we && idx_q == 5'(k)) begin
          col_q[k]   <= col_store;
          valid_q[k] <= 1'b1;
        end
`endif
      end
    end
  end

  // Descending scan so the lowest matching slot index has the final say.
  always_comb begin
    hit     = 1'b0;
    hit_col = 6'h00;
    for (int k = NUM_POINTS - 1; k >= 0; k--) begin
      if (valid_q[k] && cell_x == x_q[k] && cell_y == y_q[k]) begin
        hit = 1'b1;
`ifdef RAND_POINT_COLOR_EN
        hit_col = col_q[k];
`else
        hit_col = 6'h3F;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rgb_q <= 6'h00;
    else          rgb_q <= (video_active && hit) ? hit_col : 6'h00;
  end

endmodule

// File: tb/tb_rand_point_scheduler.sv
// Self-checking bench for rand_point_scheduler: directed vector table, hand sequences,
// and randomized frames compared against a queue-based placement model.
module tb_rand_point_scheduler;
  localparam int NP   = 8;
  localparam int MAXT = 64;
  localparam int COLS = 40;
  localparam int ROWS = 30;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] randNum;
  logic        frameStart;
  logic [9:0]  pixX, pixY;
  logic        videoActive;
  logic [5:0]  rgb;
  logic        busy;
  logic [4:0]  numValid;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  rand_point_scheduler #(
    .NUM_POINTS(NP), .CELL_SHIFT(4), .COLS(COLS), .ROWS(ROWS), .MAX_TRIES(MAXT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rand_num(randNum), .frame_start(frameStart),
    .pix_x(pixX), .pix_y(pixY), .video_active(videoActive),
    .rgb(rgb), .busy(busy), .num_valid(numValid)
  );

  // Reference model: phase 0 idle, 1 sampling positions, 2 sampling a colour, 3 showing
  bit         modelOn = 1'b0;
  int         mPhase;
  int         mTries;
  int         mX[$], mY[$], mC[$];
  int         pendX, pendY;
  logic [5:0] mRgb;

  task automatic modelReset();
    mPhase = 0; mTries = 0; mRgb = 6'h00;
    mX.delete(); mY.delete(); mC.delete();
  endtask

  task automatic modelStep();
    int hitCol, sx, sy, col;
    bit acc;
    hitCol = -1;
    for (int k = 0; k < mX.size(); k++) begin
      if (int'(pixX) / 16 == mX[k] && int'(pixY) / 16 == mY[k]) begin
        hitCol = mC[k];
        break;
      end
    end
    sx  = int'(randNum[11:6]);
    sy  = int'(randNum[5:0]);
    acc = (sx < COLS) && (sy < ROWS);
    col = (sy == 0) ? 63 : sy;
    if (frameStart) begin
      mX.delete(); mY.delete(); mC.delete();
      mTries = 0; mPhase = 1;
    end else if (mPhase == 1) begin
      if (mTries < 255) mTries++;
`ifdef RAND_POINT_COLOR_EN
      if (acc) begin pendX = sx; pendY = sy; mPhase = 2; end
      else if (mTries == MAXT) mPhase = 3;
`else
      if (acc) begin mX.push_back(sx); mY.push_back(sy); mC.push_back(63); end
      if (mX.size() == NP || mTries == MAXT) mPhase = 3;
`endif
    end else if (mPhase == 2) begin
      mX.push_back(pendX); mY.push_back(pendY); mC.push_back(col);
      mPhase = (mX.size() == NP || mTries == MAXT) ? 3 : 1;
    end
    mRgb = (videoActive && hitCol >= 0) ? 6'(hitCol) : 6'h00;
  endtask

  task automatic applyStimulus(input logic fs, input logic [11:0] rn,
                               input logic [9:0] px, input logic [9:0] py, input logic va);
    frameStart = fs; randNum = rn; pixX = px; pixY = py; videoActive = va;
  endtask

  task automatic tick();
    if (modelOn) modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [5:0] expRgb,
                             input logic expBusy, input logic [4:0] expNv);
    checkInt({name, ".rgb"}, int'(rgb), int'(expRgb));
    checkInt({name, ".busy"}, int'(busy), int'(expBusy));
    checkInt({name, ".num_valid"}, int'(numValid), int'(expNv));
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, mRgb, (mPhase == 1 || mPhase == 2), 5'(mX.size()));
  endtask

  task automatic applyReset();
    reset_n = 1'b0;
    applyStimulus(1'b0, 12'h000, 10'd0, 10'd0, 1'b0);
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 6'h00, 1'b0, 5'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (busy && cycles < 300) begin
      tick();
      cycles++;
    end
  endtask

  typedef struct {
    logic        fs;
    logic [11:0] rn;
    logic [9:0]  px, py;
    logic        va;
    logic [5:0]  rgb;
    logic        busy;
    logic [4:0]  nv;
  } vec_t;

  vec_t vecs[$];

  localparam logic [11:0] ACC53 = {6'd5, 6'd3};
  localparam logic [11:0] REJ   = {6'd40, 6'd0};

  initial begin
    int cycles;
    vec_t v;
    applyStimulus(1'b0, 12'h000, 10'd0, 10'd0, 1'b0);
    applyReset();

`ifdef RAND_POINT_COLOR_EN
    applyStimulus(1'b1, 12'h000, 10'd0, 10'd0, 1'b0);
    tick();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, (i % 2 == 0) ? {6'd1, 6'd1} : {6'd0, 6'h00}, 10'd0, 10'd0, 1'b0);
      tick();
    end
    checkOutput("colourZeroDone", 6'h00, 1'b0, 5'd8);
    applyStimulus(1'b0, 12'h000, 10'd16, 10'd16, 1'b1);
    tick();
    checkOutput("colourZeroWhite", 6'h3F, 1'b0, 5'd8);
    applyStimulus(1'b1, 12'h000, 10'd0, 10'd0, 1'b0);
    tick();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, (i % 2 == 0) ? {6'd1, 6'd1} : {6'd0, 6'h30}, 10'd0, 10'd0, 1'b0);
      tick();
    end
    checkOutput("colour30Done", 6'h00, 1'b0, 5'd8);
    applyStimulus(1'b0, 12'h000, 10'd20, 10'd30, 1'b1);
    tick();
    checkOutput("colour30Pixel", 6'h30, 1'b0, 5'd8);
`else
    // Frame with 8 accepted samples at cell (5,3), then pixel probes around it
    vecs.push_back('{1'b1, 12'h000, 10'd0,  10'd0,  1'b0, 6'h00, 1'b1, 5'd0});
    for (int i = 1; i <= 8; i++) begin
      v = '{1'b0, ACC53, 10'd0, 10'd0, 1'b0, 6'h00, (i < 8), 5'(i)};
      vecs.push_back(v);
    end
    vecs.push_back('{1'b0, 12'h000, 10'd80, 10'd48, 1'b1, 6'h3F, 1'b0, 5'd8});
    vecs.push_back('{1'b0, 12'h000, 10'd95, 10'd63, 1'b1, 6'h3F, 1'b0, 5'd8});
    vecs.push_back('{1'b0, 12'h000, 10'd96, 10'd48, 1'b1, 6'h00, 1'b0, 5'd8});
    vecs.push_back('{1'b0, 12'h000, 10'd85, 10'd47, 1'b1, 6'h00, 1'b0, 5'd8});
    vecs.push_back('{1'b0, 12'h000, 10'd88, 10'd50, 1'b1, 6'h3F, 1'b0, 5'd8});
    vecs.push_back('{1'b0, 12'h000, 10'd79, 10'd50, 1'b1, 6'h00, 1'b0, 5'd8});
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].fs, vecs[i].rn, vecs[i].px, vecs[i].py, vecs[i].va);
      tick();
      checkOutput($sformatf("vec%0d", i), vecs[i].rgb, vecs[i].busy, vecs[i].nv);
    end

    // Hit cell with video inactive, then active
    applyStimulus(1'b0, 12'h000, 10'd90, 10'd60, 1'b0);
    tick();
    checkOutput("videoOff", 6'h00, 1'b0, 5'd8);
    applyStimulus(1'b0, 12'h000, 10'd90, 10'd60, 1'b1);
    tick();
    checkOutput("videoOn", 6'h3F, 1'b0, 5'd8);

    // Asynchronous reset mid-SHOW while a point is being drawn
    reset_n = 1'b0;
    #1;
    checkOutput("asyncReset", 6'h00, 1'b0, 5'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    checkOutput("afterReset", 6'h00, 1'b0, 5'd0);

    // All samples rejected: tries cap ends the frame
    applyStimulus(1'b1, REJ, 10'd0, 10'd0, 1'b1);
    tick();
    applyStimulus(1'b0, REJ, 10'd0, 10'd0, 1'b1);
    waitIdle(cycles);
    checkInt("rejectWindow", cycles, MAXT);
    checkOutput("rejectDone", 6'h00, 1'b0, 5'd0);

    // Restart on the fourth sample cycle of a capture
    applyStimulus(1'b1, ACC53, 10'd0, 10'd0, 1'b0);
    tick();
    applyStimulus(1'b0, ACC53, 10'd0, 10'd0, 1'b0);
    repeat (3) tick();
    checkOutput("preRestart", 6'h00, 1'b1, 5'd3);
    applyStimulus(1'b1, ACC53, 10'd0, 10'd0, 1'b0);
    tick();
    checkOutput("restart", 6'h00, 1'b1, 5'd0);
    applyStimulus(1'b0, REJ, 10'd0, 10'd0, 1'b0);
    waitIdle(cycles);
    checkInt("restartWindow", cycles, MAXT);
    checkInt("restartNv", int'(numValid), 0);
`endif

    // Randomized frames against the reference model
    applyReset();
    modelOn = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      logic fs, va;
      logic [9:0] px, py;
      int pick;
      fs = (i == 0) || ($urandom_range(0, 79) == 0);
      va = ($urandom_range(0, 3) != 0);
      if (mX.size() > 0 && $urandom_range(0, 1) == 1) begin
        pick = $urandom_range(0, mX.size() - 1);
        px = 10'(mX[pick] * 16 + $urandom_range(0, 15));
        py = 10'(mY[pick] * 16 + $urandom_range(0, 15));
      end else begin
        px = 10'($urandom_range(0, 1023));
        py = 10'($urandom_range(0, 1023));
      end
      applyStimulus(fs, 12'($urandom), px, py, va);
      tick();
      checkModel($sformatf("rand%0d", i));
    end
    modelOn = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
